// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier: one multiplier bit per cycle, LSB first,
// into a double-width accumulator; low half to R, high half folded into OVF.
module shift_add_mul #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] R,
   output logic             OVF
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic               ovf_q, ovf_d;
   logic [2*WIDTH-1:0] sum;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         r_q      <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
         ovf_q    <= ovf_d;
      end
   end

   // Multiplicand shifts left while the multiplier shifts right,
   // so the current bit is always mplier_q[0].
   assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE, FIN: begin
            if (START) begin
               mcand_d  = {{WIDTH{1'b0}}, X};
               mplier_d = Y;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = FIN;
               r_d     = sum[WIDTH-1:0];
               ovf_d   = |sum[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign BUSY = (state_q == RUN);
   assign DONE = (state_q == FIN);
   assign R    = r_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Randomized self-checking bench for shift_add_mul against a
// plain 64-bit multiply reference.
module tb_shift_add_mul;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        START;
   logic [31:0] X, Y;
   logic        BUSY, DONE, OVF;
   logic [31:0] R;

   int checks = 0;
   int errors = 0;
   logic [31:0] prev_r = '0;
   logic        prev_ovf = 1'b0;

   shift_add_mul #(.WIDTH(32)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .X(X), .Y(Y),
      .BUSY(BUSY), .DONE(DONE), .R(R), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Full-precision reference product.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic run_op(input logic [31:0] a, b, input bit scramble,
                         input string name);
      logic [63:0] p;
      int n;
      bit bad;
      p = ref_prod(a, b);
      START = 1'b1; X = a; Y = b;
      tick();
      START = 1'b0;
      n = 0; bad = 0;
      while (!DONE && n < 40) begin
         if (BUSY !== 1'b1 || R !== prev_r || OVF !== prev_ovf) bad = 1;
         if (scramble) begin X = $urandom; Y = $urandom; end
         tick();
         n++;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s run: BUSY=%b R=%h OVF=%b, required BUSY=1 R=%h OVF=%b held",
                  name, BUSY, R, OVF, prev_r, prev_ovf);
      end
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL %s latency: got %0d edges, required 32", name, n);
      end
      checks++;
      if (R !== p[31:0] || OVF !== (|p[63:32]) || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL %s result: R=%h OVF=%b BUSY=%b, required R=%h OVF=%b BUSY=0",
                  name, R, OVF, BUSY, p[31:0], |p[63:32]);
      end
      prev_r = p[31:0];
      prev_ovf = |p[63:32];
      tick();
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || R !== prev_r) begin
         errors++;
         $display("FAIL %s after: DONE=%b BUSY=%b R=%h, required 0 0 %h",
                  name, DONE, BUSY, R, prev_r);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; START = 1'b0; X = '0; Y = '0;
      tick(); tick();
      checks++;
      if (BUSY !== 0 || DONE !== 0 || R !== 0 || OVF !== 0) begin
         errors++;
         $display("FAIL reset: BUSY=%b DONE=%b R=%h OVF=%b, required all 0",
                  BUSY, DONE, R, OVF);
      end
      RST_N = 1'b1;
      tick();
      checks++;
      if (BUSY !== 0 || DONE !== 0) begin
         errors++;
         $display("FAIL idle: BUSY=%b DONE=%b, required 0 0", BUSY, DONE);
      end
   endtask

   task automatic test_directed();
      run_op(32'd3, 32'd4, 1'b0, "3x4");
      run_op(32'hFFFF_FFFF, 32'd2, 1'b0, "max_x2");
      run_op(32'h0001_0000, 32'h0001_0000, 1'b0, "2p16sq");
      run_op(32'd0, 32'hDEAD_BEEF, 1'b1, "zero_x");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "max_max");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         run_op($urandom, (i % 2) ? $urandom : ($urandom & 32'hFFFF), 1'b1, "rand");
   endtask

   task automatic test_start_ignored();
      int n;
      START = 1'b1; X = 32'd5; Y = 32'd6;
      tick();
      START = 1'b0;
      n = 0;
      while (!DONE && n < 40) begin
         if (n == 5) begin START = 1'b1; X = 32'd7; Y = 32'd7; end
         else START = 1'b0;
         tick();
         n++;
      end
      START = 1'b0;
      checks++;
      if (n !== 32 || R !== 32'd30 || OVF !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: edges=%0d R=%0d OVF=%b, required 32 30 0",
                  n, R, OVF);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (R !== 32'd30 || DONE !== 0 || BUSY !== 0) begin
            errors++;
            $display("FAIL hold: R=%0d DONE=%b BUSY=%b, required 30 0 0",
                     R, DONE, BUSY);
         end
      end
      prev_r = 32'd30;
      prev_ovf = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      START = 1'b1; X = 32'd9; Y = 32'd9;
      tick();
      START = 1'b0;
      repeat (10) tick();
      RST_N = 1'b0;
      #1;
      checks++;
      if (BUSY !== 0 || DONE !== 0 || R !== 0 || OVF !== 0) begin
         errors++;
         $display("FAIL abort: BUSY=%b DONE=%b R=%h OVF=%b, required all 0",
                  BUSY, DONE, R, OVF);
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (DONE !== 0 || R !== 0) begin
            errors++;
            $display("FAIL abort_hold: DONE=%b R=%h, required 0 0", DONE, R);
         end
      end
      RST_N = 1'b1;
      prev_r = '0;
      prev_ovf = 1'b0;
      run_op(32'd2, 32'd3, 1'b0, "post_reset");
   endtask

   task automatic test_back_to_back();
      int n;
      START = 1'b1; X = 32'd1; Y = 32'd1;
      tick();
      n = 0;
      while (!DONE && n < 40) begin tick(); n++; end
      checks++;
      if (n !== 32 || R !== 32'd1) begin
         errors++;
         $display("FAIL b2b_first: edges=%0d R=%0d, required 32 1", n, R);
      end
      X = 32'd2; Y = 32'd2;
      tick();
      n = 1;
      checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: BUSY=%b DONE=%b, required 1 0", BUSY, DONE);
      end
      while (!DONE && n < 40) begin tick(); n++; end
      START = 1'b0;
      checks++;
      if (n !== 33 || R !== 32'd4 || OVF !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: spacing=%0d R=%0d OVF=%b, required 33 4 0",
                  n, R, OVF);
      end
      tick();
      prev_r = 32'd4;
      prev_ovf = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
